// File: rtl/mem_arbiter.sv
// Two-master arbiter in front of memory_controller: serialises req/ack accesses and holds addr/data across the slave latency.
// Build option: define MEM_ARB_RR_EN for round-robin arbitration; otherwise master 0 has fixed priority.
module mem_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              m0_req,
    input  logic              m1_req,
    input  logic              m0_write,
    input  logic              m1_write,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic [DATA_W-1:0] m0_rdata,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m0_ack,
    output logic              m1_ack,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_wdata,
    output logic              s_read,
    output logic              s_write,
    input  logic [DATA_W-1:0] s_rdata,
    output logic              busy,
    output logic              gnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              wr_q, wr_d;
    logic              idx_q, idx_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic              win;

`ifdef MEM_ARB_RR_EN
    // pref_q names the master that wins the next contention; reset favours master 0.
    logic pref_q, pref_d;

    always_comb begin
        win = (m0_req && m1_req) ? pref_q : !m0_req;
    end
`else
    always_comb begin
        win = !m0_req;
    end
`endif

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wr_d     = wr_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
`ifdef MEM_ARB_RR_EN
        pref_d   = pref_q;
`endif
        case (state_q)
            IDLE: begin
                if (m0_req || m1_req) begin
                    idx_d   = win;
                    addr_d  = win ? m1_addr  : m0_addr;
                    wdata_d = win ? m1_wdata : m0_wdata;
                    wr_d    = win ? m1_write : m0_write;
`ifdef MEM_ARB_RR_EN
                    pref_d  = !win;
`endif
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = WAIT_LD;
                state_d = WAIT;
            end
            WAIT: begin
                // Treat 0 like 1 so an out-of-range latency can never wedge the FSM.
                if (cnt_q <= 4'd1) begin
                    if (!wr_q) begin
                        if (idx_q) rdata1_d = s_rdata;
                        else       rdata0_d = s_rdata;
                    end
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            wr_q     <= 1'b0;
            idx_q    <= 1'b0;
            cnt_q    <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
`ifdef MEM_ARB_RR_EN
            pref_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wr_q     <= wr_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
`ifdef MEM_ARB_RR_EN
            pref_q   <= pref_d;
`endif
        end
    end

    // Address/data come straight from the latch, so they stay stable from ISSUE through WAIT.
    assign s_addr   = addr_q;
    assign s_wdata  = wdata_q;
    assign s_read   = (state_q == ISSUE) && !wr_q;
    assign s_write  = (state_q == ISSUE) &&  wr_q;
    assign m0_ack   = (state_q == DONE) && !idx_q;
    assign m1_ack   = (state_q == DONE) &&  idx_q;
    assign m0_rdata = rdata0_q;
    assign m1_rdata = rdata1_q;
    assign busy     = (state_q != IDLE);
    assign gnt      = idx_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (latency 1 and 4) checked every cycle against a transaction-phase model,
// plus directed scenarios with hand-computed cycle numbers and data values.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req   [2][2];
    logic        wr    [2][2];
    logic [31:0] addr  [2][2];
    logic [31:0] wdat  [2][2];
    logic [31:0] rdat  [2][2];
    logic        ack   [2][2];
    logic [31:0] s_addr  [2];
    logic [31:0] s_wdata [2];
    logic [31:0] s_rdata [2];
    logic        s_read  [2];
    logic        s_write [2];
    logic        busy    [2];
    logic        gnt     [2];

    int errs   = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(1)) u_dut0 (
        .clk(clk), .reset_n(reset_n),
        .m0_req(req[0][0]), .m1_req(req[0][1]),
        .m0_write(wr[0][0]), .m1_write(wr[0][1]),
        .m0_addr(addr[0][0]), .m1_addr(addr[0][1]),
        .m0_wdata(wdat[0][0]), .m1_wdata(wdat[0][1]),
        .m0_rdata(rdat[0][0]), .m1_rdata(rdat[0][1]),
        .m0_ack(ack[0][0]), .m1_ack(ack[0][1]),
        .s_addr(s_addr[0]), .s_wdata(s_wdata[0]),
        .s_read(s_read[0]), .s_write(s_write[0]),
        .s_rdata(s_rdata[0]), .busy(busy[0]), .gnt(gnt[0])
    );

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(4)) u_dut1 (
        .clk(clk), .reset_n(reset_n),
        .m0_req(req[1][0]), .m1_req(req[1][1]),
        .m0_write(wr[1][0]), .m1_write(wr[1][1]),
        .m0_addr(addr[1][0]), .m1_addr(addr[1][1]),
        .m0_wdata(wdat[1][0]), .m1_wdata(wdat[1][1]),
        .m0_rdata(rdat[1][0]), .m1_rdata(rdat[1][1]),
        .m0_ack(ack[1][0]), .m1_ack(ack[1][1]),
        .s_addr(s_addr[1]), .s_wdata(s_wdata[1]),
        .s_read(s_read[1]), .s_write(s_write[1]),
        .s_rdata(s_rdata[1]), .busy(busy[1]), .gnt(gnt[1])
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Model: ph = cycles since the request was sampled (0 = idle), so ISSUE is ph 1,
    // the slave wait spans ph 2..1+W (read data taken in ph 1+W) and ack is ph 2+W.
    int          ph     [2];
    int          mm     [2];
    logic        mwr    [2];
    logic [31:0] maddr  [2];
    logic [31:0] mwd    [2];
    logic [31:0] mrd    [2][2];
    logic        mgnt   [2];
    int          rrlast [2];
    int          wk;
    int          pick;

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            wk = (k == 1) ? 4 : 1;
            if (reset_n !== 1'b1) begin
                chk("rst_busy", 32'(busy[k]), 0);
                chk("rst_s_read", 32'(s_read[k]), 0);
                chk("rst_s_write", 32'(s_write[k]), 0);
                chk("rst_s_addr", s_addr[k], 0);
                chk("rst_s_wdata", s_wdata[k], 0);
                chk("rst_ack0", 32'(ack[k][0]), 0);
                chk("rst_ack1", 32'(ack[k][1]), 0);
                chk("rst_rdata0", rdat[k][0], 0);
                chk("rst_rdata1", rdat[k][1], 0);
                chk("rst_gnt", 32'(gnt[k]), 0);
                ph[k] = 0; mm[k] = 0; mwr[k] = 0; maddr[k] = 0; mwd[k] = 0;
                mrd[k][0] = 0; mrd[k][1] = 0; mgnt[k] = 0; rrlast[k] = 1;
            end else begin
                chk("m_busy", 32'(busy[k]), 32'(ph[k] != 0));
                chk("m_s_read", 32'(s_read[k]), 32'(ph[k] == 1 && !mwr[k]));
                chk("m_s_write", 32'(s_write[k]), 32'(ph[k] == 1 && mwr[k]));
                chk("m_ack0", 32'(ack[k][0]), 32'(ph[k] == wk + 2 && mm[k] == 0));
                chk("m_ack1", 32'(ack[k][1]), 32'(ph[k] == wk + 2 && mm[k] == 1));
                chk("m_rdata0", rdat[k][0], mrd[k][0]);
                chk("m_rdata1", rdat[k][1], mrd[k][1]);
                chk("m_gnt", 32'(gnt[k]), 32'(mgnt[k]));
                if (ph[k] >= 1 && ph[k] <= wk + 1) begin
                    chk("m_s_addr", s_addr[k], maddr[k]);
                    chk("m_s_wdata", s_wdata[k], mwd[k]);
                end
                if (ph[k] == 0) begin
                    if (req[k][0] || req[k][1]) begin
`ifdef MEM_ARB_RR_EN
                        pick = (req[k][0] && req[k][1]) ? 1 - rrlast[k] : (req[k][0] ? 0 : 1);
`else
                        pick = req[k][0] ? 0 : 1;
`endif
                        mm[k] = pick; mwr[k] = wr[k][pick]; maddr[k] = addr[k][pick];
                        mwd[k] = wdat[k][pick]; mgnt[k] = pick[0]; rrlast[k] = pick; ph[k] = 1;
                    end
                end else if (ph[k] == wk + 1) begin
                    if (!mwr[k]) mrd[k][mm[k]] = s_rdata[k];
                    ph[k] = ph[k] + 1;
                end else if (ph[k] == wk + 2) begin
                    ph[k] = 0;
                end else begin
                    ph[k] = ph[k] + 1;
                end
            end
        end
    end

    // Per-cycle trace of one transaction, cycle 0 = cycle the request is first presented.
    logic        tr_rd   [20];
    logic        tr_wr   [20];
    logic [31:0] tr_addr [20];
    logic [31:0] tr_wd   [20];
    logic        tr_busy [20];
    logic        tr_oack [20];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic txn(input int k, input int m, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input int drop_at, output int ack_cyc);
        ack_cyc = -1;
        for (int c = 0; c < 20; c++) begin
            tr_rd[c] = 0; tr_wr[c] = 0; tr_addr[c] = 0; tr_wd[c] = 0; tr_busy[c] = 0; tr_oack[c] = 0;
        end
        req[k][m] = 1'b1; wr[k][m] = w; addr[k][m] = a; wdat[k][m] = d;
        for (int c = 0; c < 20; c++) begin
            if (c == drop_at) req[k][m] = 1'b0;
            if (k == 1) s_rdata[1] = 32'hA000_0000 + 32'(c);
            @(negedge clk);
            tr_rd[c] = s_read[k]; tr_wr[c] = s_write[k]; tr_addr[c] = s_addr[k];
            tr_wd[c] = s_wdata[k]; tr_busy[c] = busy[k]; tr_oack[c] = ack[k][1-m];
            if (ack[k][m] && ack_cyc < 0) ack_cyc = c;
            step();
            if (ack_cyc >= 0) begin
                req[k][m] = 1'b0;
                if (c >= ack_cyc + 1) break;
            end
        end
        req[k][m] = 1'b0;
    endtask

    int ac;
    int n;
    int seq [4];
    int exp_seq [4];

    initial begin
        reset_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            for (int m = 0; m < 2; m++) begin
                req[k][m] = 0; wr[k][m] = 0; addr[k][m] = 0; wdat[k][m] = 0;
            end
            s_rdata[k] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("init_busy0", 32'(busy[0]), 0);
        chk("init_gnt0", 32'(gnt[0]), 0);
        chk("init_rdata1_k1", rdat[1][1], 0);
        reset_n = 1'b1;
        step();

        // Single read, latency 1
        s_rdata[0] = 32'hDEAD_BEEF;
        txn(0, 0, 1'b0, 32'h1000_0004, 32'h0, -1, ac);
        chk("rd_ack_cycle", 32'(ac), 3);
        chk("rd_s_read_c1", 32'(tr_rd[1]), 1);
        chk("rd_s_read_c0", 32'(tr_rd[0]), 0);
        chk("rd_s_read_c2", 32'(tr_rd[2]), 0);
        chk("rd_s_addr_c1", tr_addr[1], 32'h1000_0004);
        chk("rd_m0_rdata", rdat[0][0], 32'hDEAD_BEEF);
        chk("rd_m1_ack_c3", 32'(tr_oack[3]), 0);
        chk("rd_idle_c4", 32'(tr_busy[4]), 0);
        step();

        // Write from master 1
        s_rdata[0] = 32'hFFFF_0000;
        txn(0, 1, 1'b1, 32'h2000_0000, 32'h1234_5678, -1, ac);
        chk("wr_ack_cycle", 32'(ac), 3);
        chk("wr_s_write_c1", 32'(tr_wr[1]), 1);
        chk("wr_s_write_c2", 32'(tr_wr[2]), 0);
        chk("wr_s_read_c1", 32'(tr_rd[1]), 0);
        chk("wr_s_addr_c1", tr_addr[1], 32'h2000_0000);
        chk("wr_s_wdata_c1", tr_wd[1], 32'h1234_5678);
        chk("wr_m1_rdata", rdat[0][1], 32'h0);
        chk("wr_m0_rdata", rdat[0][0], 32'hDEAD_BEEF);
        step();

        // Contention: both masters keep requesting for four transactions
`ifdef MEM_ARB_RR_EN
        exp_seq = '{0, 1, 0, 1};
`else
        exp_seq = '{0, 0, 0, 0};
`endif
        req[0][0] = 1; wr[0][0] = 1; addr[0][0] = 32'h0000_0500; wdat[0][0] = 32'h0000_0011;
        req[0][1] = 1; wr[0][1] = 0; addr[0][1] = 32'h0000_0600; wdat[0][1] = 32'h0000_0022;
        n = 0;
        for (int c = 0; c < 40 && n < 4; c++) begin
            s_rdata[0] = 32'hC000_0000 + 32'(c);
            @(negedge clk);
            if (ack[0][0] && n < 4) begin seq[n] = 0; n++; end
            if (ack[0][1] && n < 4) begin seq[n] = 1; n++; end
            step();
        end
        req[0][0] = 0; req[0][1] = 0;
        chk("cont_ack_count", 32'(n), 4);
        for (int i = 0; i < 4; i++) chk("cont_grant_seq", 32'(seq[i]), 32'(exp_seq[i]));
        repeat (4) step();

        // Request dropped right after it was sampled
        s_rdata[0] = 32'h0BAD_F00D;
        txn(0, 0, 1'b0, 32'h0000_0300, 32'h0, 1, ac);
        chk("drop_ack_cycle", 32'(ac), 3);
        chk("drop_idle_c4", 32'(tr_busy[4]), 0);
        chk("drop_m0_rdata", rdat[0][0], 32'h0BAD_F00D);
        step();

        // Latency 4 instance: s_rdata carries the cycle number
        txn(1, 0, 1'b0, 32'h4000_0010, 32'h0, -1, ac);
        chk("lat_ack_cycle", 32'(ac), 6);
        chk("lat_s_read_c1", 32'(tr_rd[1]), 1);
        for (int c = 1; c <= 5; c++) chk("lat_s_addr_stable", tr_addr[c], 32'h4000_0010);
        chk("lat_m0_rdata", rdat[1][0], 32'hA000_0005);
        step();

        // Reset asserted while the slave wait is in progress
        req[0][0] = 1; wr[0][0] = 0; addr[0][0] = 32'h0000_0700;
        step();
        step();
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy[0]), 0);
        chk("midrst_ack0", 32'(ack[0][0]), 0);
        chk("midrst_rdata0", rdat[0][0], 0);
        chk("midrst_s_addr", s_addr[0], 0);
        req[0][0] = 0;
        step();
        step();
        reset_n = 1'b1;
        req[0][0] = 1; wr[0][0] = 0; addr[0][0] = 32'h0000_0800;
        req[0][1] = 1; wr[0][1] = 0; addr[0][1] = 32'h0000_0900;
        step();
        @(negedge clk);
        chk("postrst_gnt_c1", 32'(gnt[0]), 0);
        chk("postrst_busy_c1", 32'(busy[0]), 1);
        step();
        step();
        @(negedge clk);
        chk("postrst_ack0_c3", 32'(ack[0][0]), 1);
        chk("postrst_ack1_c3", 32'(ack[0][1]), 0);
        step();
        req[0][0] = 0; req[0][1] = 0;
        repeat (4) step();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master arbiter that shares the single CPU-side port of `memory_controller` between the RV32 core (master 0) and a second bus master such as a DMA/blit engine (master 1). It sits between the masters and `memory_controller`, entirely in the `clk_100` domain. It serialises accesses with a req/ack handshake and holds address and data stable across the configured memory latency. It returns read data to the granted master only.

## Interface
Parameters:
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width.
- `WAIT_CYCLES`, 1: slave read latency in cycles, legal range 1..15.

Ports:
- `clk`  in  1: system clock (`clk_100`).
- `reset_n`  in  1: asynchronous, active-low reset.
- `m0_req`, `m1_req`  in  1 each: request; held high until ack.
- `m0_write`, `m1_write`  in  1 each: 1 = write, 0 = read.
- `m0_addr`, `m1_addr`  in  ADDR_W each: byte address.
- `m0_wdata`, `m1_wdata`  in  DATA_W each: write data.
- `m0_rdata`, `m1_rdata`  out  DATA_W each: registered read data, valid with ack.
- `m0_ack`, `m1_ack`  out  1 each: one-cycle completion pulse.
- `s_addr`  out  ADDR_W: to `memory_controller.addr`.
- `s_wdata`  out  DATA_W: to `memory_controller.wdata`.
- `s_read`  out  1: to `memory_controller.mem_read`.
- `s_write`  out  1: to `memory_controller.mem_write`.
- `s_rdata`  in  DATA_W: from `memory_controller.rdata`.
- `busy`  out  1: high in every state other than IDLE.
- `gnt`  out  1: index of the current or last granted master.

## Operation
- FSM states are IDLE, ISSUE, WAIT and DONE.
- **IDLE**
  - If any request is high, select a master, latch its addr, wdata, write and index, then go to ISSUE.
  - Otherwise stay in IDLE.
- **ISSUE**
  - Drive `s_addr` and `s_wdata` from the latched values for exactly one cycle.
  - Assert `s_write` if the latched write bit is set, else `s_read`.
  - Load the wait counter with `WAIT_CYCLES`, then go to WAIT.
- **WAIT**
  - `s_addr` and `s_wdata` stay at the latched values; `s_read` and `s_write` are 0.
  - The counter decrements each cycle.
  - When the counter reaches 1, sample `s_rdata` into the granted master's rdata register (reads only) and go to DONE.
- **DONE**
  - Pulse the granted master's ack for one cycle, then go to IDLE.
  - No arbitration happens in this state.
- Read data:
  - `mX_rdata` holds its value until that master's next completed read.
  - Writes never modify any `mX_rdata`.
- Arbitration:
  - Only the IDLE state arbitrates.
  - Master inputs are sampled only in IDLE; changes during ISSUE, WAIT or DONE are ignored.
- Request dropped mid-transaction: the transaction still completes and ack still pulses.
- Reset:
  - All registers and outputs go to 0 and the FSM goes to IDLE immediately, including mid-transaction.
  - The round-robin pointer resets so that master 0 wins the first contention.

## Timing
- Request sampled in IDLE at cycle 0:
  - ISSUE at cycle 1.
  - WAIT at cycles 2 .. 1+WAIT_CYCLES.
  - ack at cycle 2+WAIT_CYCLES; this is 3 cycles for the default.
  - IDLE at cycle 3+WAIT_CYCLES.
- Throughput is one transaction per 3+WAIT_CYCLES cycles. A request held high after ack starts a new transaction at the next IDLE.
- A master must deassert req in the cycle after ack if no further access is wanted.
- Reset value of every output is 0, including `s_addr`, `s_wdata`, both `mX_rdata`, both acks, `busy` and `gnt`.
- The ack of one master and a grant to the other never coincide in the same cycle.

## Configuration
- Macro: `MEM_ARB_RR_EN`.
- Defined: round-robin arbitration.
  - On simultaneous requests, grant the master not granted most recently.
  - A single requester is always granted.
- Undefined: fixed priority.
  - Master 0 always wins simultaneous requests.
  - Master 1 can starve.
  - The round-robin pointer logic is compiled out.

## Test plan
- Single read: m0 reads 0x1000_0004 with slave returning 0xDEAD_BEEF, WAIT_CYCLES=1.
  - `s_read` is high only in cycle 1 with `s_addr`=0x1000_0004.
  - `m0_ack` is high in cycle 3 with `m0_rdata`=0xDEAD_BEEF.
  - `m1_ack` stays 0.
- Write: m1 writes 0x1234_5678 to 0x2000_0000.
  - `s_write` is high for one cycle with matching addr and data.
  - `m1_ack` is high in cycle 3.
  - `m1_rdata` is unchanged.
- Contention: m0 and m1 both hold req for 4 transactions.
  - With `MEM_ARB_RR_EN` defined, grants are 0,1,0,1.
  - With it undefined, all 4 grants go to 0 and m1 is never acked.
- Latency: WAIT_CYCLES=4, m0 read.
  - ack at cycle 6.
  - `s_addr` is stable over cycles 1..5.
  - `s_rdata` is sampled in cycle 5.
- Dropped request: m0 drops req in cycle 1; `m0_ack` still pulses at cycle 3 and the FSM returns to IDLE.
- Reset mid-op: assert `reset_n`=0 during WAIT.
  - All outputs are 0 immediately and no ack is generated.
  - After release, the next simultaneous request grants m0.
